ppu_pack_writer: RTL

- Sits directly downstream of the PPU; consumes its registered 8-bit quantized outputs (data_out/valid).
- Packs bytes little-endian into 32-bit words and buffers them in a small FIFO.
- Writes words to the global buffer (GLB) through a valid/ready write port at consecutive word addresses.
- On end of tile, flushes any partial word with a byte strobe, drains, then pulses done.

---
 rtl/ppu_pack_writer_if.sv | 27 ++
 rtl/ppu_pack_writer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ppu_pack_writer_if.sv
// GLB write port between the pack writer (master) and the global buffer (slave).
// Valid/ready handshake; one 32-bit word per completed transfer.
interface ppu_pack_writer_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              glb_we;
    logic [ADDR_W-1:0] glb_addr;
    logic [31:0]       glb_wdata;
    logic [3:0]        glb_wstrb;
    logic              glb_ready;

    modport master (
        output glb_we,
        output glb_addr,
        output glb_wdata,
        output glb_wstrb,
        input  glb_ready
    );

    modport slave (
        input  glb_we,
        input  glb_addr,
        input  glb_wdata,
        input  glb_wstrb,
        output glb_ready
    );
endinterface

// File: rtl/ppu_pack_writer.sv
// Packs PPU bytes little-endian into 32-bit words, buffers them in a small FIFO and
// writes them to the GLB at consecutive word addresses; flushes partial words at end of tile.
module ppu_pack_writer #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 i_valid,
    input  logic [7:0]           i_data,
    input  logic                 i_flush,
    output logic                 o_ready,
    ppu_pack_writer_if.master    glb_io,
    output logic [ADDR_W-1:0]    o_word_cnt,
    output logic                 o_overflow,
    output logic                 o_done
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q;
    logic [31:0]       fifo_data_q [FIFO_DEPTH];
    logic [3:0]        fifo_strb_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [31:0]       word_q, word_d, word_acc;
    logic [1:0]        byte_cnt_q, byte_cnt_d, cnt_acc;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, word_cnt_q;
    logic              ovf_q;

    logic              ready, not_full, accept, pop, push;
    logic [31:0]       push_data;
    logic [3:0]        push_strb;

    function automatic logic [3:0] lane_mask(input logic [1:0] k);
        return 4'((5'd1 << k) - 5'd1);
    endfunction

    assign not_full = count_q < CntW'(FIFO_DEPTH);
    assign ready    = (state_q == StRun) && not_full;
    assign accept   = i_valid && ready;
    assign pop      = (count_q != '0) && glb_io.glb_ready;

    always_comb begin
        word_acc   = word_q;
        cnt_acc    = byte_cnt_q;
        if (accept) begin
            word_acc[{byte_cnt_q, 3'b000} +: 8] = i_data;
            cnt_acc = byte_cnt_q + 2'd1;
        end
        word_d     = word_acc;
        byte_cnt_d = cnt_acc;
        pend_d     = pend_q;
        push       = 1'b0;
        push_data  = word_acc;
        push_strb  = 4'hF;
        if (accept && byte_cnt_q == 2'd3) begin
            push   = 1'b1;
            word_d = '0;
        end else if (state_q == StRun && i_flush && cnt_acc != 2'd0) begin
            // A partial word that cannot fit now is parked and pushed from DRAIN.
            if (not_full) begin
                push       = 1'b1;
                push_strb  = lane_mask(cnt_acc);
                word_d     = '0;
                byte_cnt_d = 2'd0;
            end else begin
                pend_d = 1'b1;
            end
        end
        if (state_q == StDrain && pend_q && not_full) begin
            push       = 1'b1;
            push_data  = word_q;
            push_strb  = lane_mask(byte_cnt_q);
            word_d     = '0;
            byte_cnt_d = 2'd0;
            pend_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            word_q     <= '0;
            byte_cnt_q <= 2'd0;
            pend_q     <= 1'b0;
            addr_q     <= '0;
            word_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            pend_q     <= pend_d;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= push_data;
                fifo_strb_q[wr_ptr_q] <= push_strb;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                addr_q     <= addr_q + 1'b1;
                word_cnt_q <= word_cnt_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            unique case (state_q)
                StIdle: if (i_start) begin
                    state_q    <= StRun;
                    addr_q     <= base_addr;
                    word_cnt_q <= '0;
                    word_q     <= '0;
                    byte_cnt_q <= 2'd0;
                    pend_q     <= 1'b0;
                    ovf_q      <= 1'b0;
                end
                StRun:   if (i_flush) state_q <= StDrain;
                StDrain: if (count_q == '0 && !pend_q) state_q <= StDone;
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            // A byte dropped in the same cycle as a start still counts as an overflow.
            if (i_valid && !ready) ovf_q <= 1'b1;
        end
    end

    assign o_ready          = ready;
    assign o_word_cnt       = word_cnt_q;
    assign o_overflow       = ovf_q;
    assign o_done           = (state_q == StDone);
    assign glb_io.glb_we    = (count_q != '0);
    assign glb_io.glb_addr  = addr_q;
    assign glb_io.glb_wdata = glb_io.glb_we ? fifo_data_q[rd_ptr_q] : 32'h0;
    assign glb_io.glb_wstrb = glb_io.glb_we ? fifo_strb_q[rd_ptr_q] : 4'h0;
endmodule
